mpc_shared_op_arbiter: RTL and testbench

Round-robin arbiter and tag tracker that shares one fixed-latency, fully pipelined 32-bit operator (e.g. the MPC fmul/fadd core behind the 4:1 operand mux) among four requesters. It accepts at most one operand pair per cycle and drives the operator's operands, issue strobe and 2-bit mux select. It tracks every in-flight operation by requester index and returns each result to the requester that issued it. It sits in the MPC controller datapath between the matrix-update loops and the shared arithmetic core.

---
 rtl/mpc_shared_op_arbiter.sv | 94 +++++++++
 tb/tb_mpc_shared_op_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mpc_shared_op_arbiter.sv
// Round-robin front end for one shared fixed-latency pipelined operator.
// It tags each issued operation with its requester and routes the result back to that requester.
module mpc_shared_op_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int LATENCY    = 4
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [3:0]              req_valid,
  input  logic [4*DATA_WIDTH-1:0] req_a,
  input  logic [4*DATA_WIDTH-1:0] req_b,
  output logic [3:0]              req_ready,
  output logic [DATA_WIDTH-1:0]   op_a,
  output logic [DATA_WIDTH-1:0]   op_b,
  output logic                    op_vld,
  output logic [1:0]              op_sel,
  input  logic [DATA_WIDTH-1:0]   op_res,
  output logic [3:0]              resp_valid,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    busy
);

  logic [3:0][DATA_WIDTH-1:0] a_lane, b_lane;
  assign a_lane = req_a;
  assign b_lane = req_b;

  logic [1:0]            ptr_q, ptr_d;
  logic [1:0]            win, cand;
  logic                  win_found, accept;
  logic [DATA_WIDTH-1:0] op_a_q, op_b_q, resp_data_q;
  logic                  op_vld_q;
  logic [1:0]            op_sel_q;
  logic [3:0]            resp_valid_q;
  logic [LATENCY-1:0]    vld_pipe_q;
  logic [LATENCY-1:0][1:0] idx_pipe_q;

  // First valid requester at or after ptr wins.
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    cand      = ptr_q;
    for (int k = 0; k < 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win       = cand;
      end
    end
  end

  assign accept    = win_found && ap_rst_n;
  assign req_ready = accept ? (4'b0001 << win) : 4'b0000;
  assign ptr_d     = accept ? (win + 2'd1) : ptr_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      ptr_q        <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_vld_q     <= 1'b0;
      op_sel_q     <= '0;
      vld_pipe_q   <= '0;
      idx_pipe_q   <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      ptr_q    <= ptr_d;
      op_vld_q <= accept;
      if (accept) begin
        op_a_q   <= a_lane[win];
        op_b_q   <= b_lane[win];
        op_sel_q <= win;
      end
      // Tag pipeline: last stage lines up with op_res of the same operation.
      vld_pipe_q[0] <= op_vld_q;
      idx_pipe_q[0] <= op_sel_q;
      for (int k = 1; k < LATENCY; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        idx_pipe_q[k] <= idx_pipe_q[k-1];
      end
      resp_valid_q <= vld_pipe_q[LATENCY-1] ? (4'b0001 << idx_pipe_q[LATENCY-1]) : 4'b0000;
      if (vld_pipe_q[LATENCY-1]) resp_data_q <= op_res;
    end
  end

  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign op_vld     = op_vld_q;
  assign op_sel     = op_sel_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign busy       = op_vld_q | (|vld_pipe_q);

endmodule

// File: tb/tb_mpc_shared_op_arbiter.sv
// Bench for mpc_shared_op_arbiter: XOR operator with LATENCY delay, queue-based reference model,
// table of grant patterns, directed corner sequences and a randomized run.
module tb_mpc_shared_op_arbiter;
  localparam int LATENCY = 4;

  logic              ap_clk = 1'b0;
  logic              ap_rst_n;
  logic [3:0]        rv;
  logic [3:0][31:0]  ra, rb;
  logic [3:0]        req_ready;
  logic [31:0]       op_a, op_b, op_res, resp_data;
  logic              op_vld, busy;
  logic [1:0]        op_sel;
  logic [3:0]        resp_valid;

  mpc_shared_op_arbiter #(.DATA_WIDTH(32), .LATENCY(LATENCY)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .req_valid(rv), .req_a(ra), .req_b(rb),
    .req_ready(req_ready), .op_a(op_a), .op_b(op_b), .op_vld(op_vld), .op_sel(op_sel),
    .op_res(op_res), .resp_valid(resp_valid), .resp_data(resp_data), .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  // Shared operator: result = a ^ b, LATENCY cycles after op_vld; garbage otherwise.
  logic [31:0] dly [LATENCY];
  always @(posedge ap_clk) begin
    dly[0] <= op_vld ? (op_a ^ op_b) : $urandom;
    for (int k = 1; k < LATENCY; k++) dly[k] <= dly[k-1];
  end
  assign op_res = dly[LATENCY-1];

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Reference model: pending results in issue order, each with the edge where it must appear.
  typedef struct { int idx; logic [31:0] d; int due; } ent_t;
  ent_t        q[$];
  int          ec = 0, m_ptr = 0, m_acc = -1;
  logic        e_opvld = 0;
  logic [1:0]  e_opsel = 0;
  logic [31:0] e_opa = 0, e_opb = 0, e_rd = 0;
  logic [3:0]  e_rv = 0;

  function automatic int pick(input logic [3:0] v, input int p);
    for (int d = 0; d < 4; d++) if (v[(p + d) % 4]) return (p + d) % 4;
    return -1;
  endfunction

  task automatic model_edge();
    int w;
    ent_t e;
    ec++;
    m_acc = -1;
    if (!ap_rst_n) begin
      m_ptr = 0; q.delete();
      e_opvld = 0; e_opsel = 0; e_opa = 0; e_opb = 0; e_rv = 0; e_rd = 0;
    end else begin
      e_rv = 0;
      if (q.size() > 0 && q[0].due == ec) begin
        e_rv = 4'b0001 << q[0].idx;
        e_rd = q[0].d;
        void'(q.pop_front());
      end
      w = pick(rv, m_ptr);
      e_opvld = (w >= 0);
      if (w >= 0) begin
        e.idx = w; e.d = ra[w] ^ rb[w]; e.due = ec + LATENCY + 1;
        q.push_back(e);
        e_opsel = 2'(w); e_opa = ra[w]; e_opb = rb[w];
        m_ptr = (w + 1) % 4;
        m_acc = w;
      end
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    model_edge();
    #2;
    chk("op_vld", {31'b0, op_vld}, {31'b0, e_opvld});
    if (e_opvld) chk("op_sel", {30'b0, op_sel}, {30'b0, e_opsel});
    chk("op_a", op_a, e_opa);
    chk("op_b", op_b, e_opb);
    chk("resp_valid", {28'b0, resp_valid}, {28'b0, e_rv});
    chk("resp_data", resp_data, e_rd);
    chk("busy", {31'b0, busy}, {31'b0, q.size() > 0});
  endtask

  task automatic apply();
    int w;
    logic [3:0] er;
    #1;
    w = pick(rv, m_ptr);
    er = (ap_rst_n && w >= 0) ? (4'b0001 << w) : 4'b0000;
    chk("req_ready", {28'b0, req_ready}, {28'b0, er});
  endtask

  typedef struct { logic [3:0] rv; logic [3:0] rdy; } vec_t;
  vec_t tbl [14];

  initial begin
    int cnt, first, last;
    tbl[0]  = '{4'b1111, 4'b0001}; tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100}; tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1010, 4'b0010}; tbl[5]  = '{4'b1010, 4'b1000};
    tbl[6]  = '{4'b1010, 4'b0010}; tbl[7]  = '{4'b1011, 4'b1000};
    tbl[8]  = '{4'b1011, 4'b0001}; tbl[9]  = '{4'b1011, 4'b0010};
    tbl[10] = '{4'b0000, 4'b0000}; tbl[11] = '{4'b0100, 4'b0100};
    tbl[12] = '{4'b0001, 4'b0001}; tbl[13] = '{4'b0001, 4'b0001};

    ap_rst_n = 1'b0; rv = 4'b1111; ra = '0; rb = '0;
    repeat (3) begin apply(); tick(); end
    ap_rst_n = 1'b1;

    // Grant sequence from reset: contention, fairness, late arrival of requester 0.
    for (int i = 0; i < 14; i++) begin
      rv = tbl[i].rv;
      for (int j = 0; j < 4; j++) begin ra[j] = 32'(j) + 32'(i * 16); rb[j] = $urandom; end
      #1;
      chk("tbl_ready", {28'b0, req_ready}, {28'b0, tbl[i].rdy});
      apply();
      tick();
    end
    rv = 0; apply();
    repeat (LATENCY + 3) tick();

    // Single op from requester 2.
    rv = 4'b0100; ra[2] = 32'h3F800000; rb[2] = 32'h40000000; apply();
    tick();
    rv = 0; apply();
    chk("single_sel", {30'b0, op_sel}, 32'd2);
    repeat (LATENCY) begin
      chk("single_busy", {31'b0, busy}, 32'd1);
      tick();
    end
    tick();
    chk("single_resp_valid", {28'b0, resp_valid}, 32'b0100);
    chk("single_resp_data", resp_data, 32'h7F800000);
    chk("single_busy_end", {31'b0, busy}, 32'd0);

    // Reset with three operations in flight.
    rv = 4'b0001; ra[0] = 32'h11; apply(); tick();
    rv = 4'b0010; ra[1] = 32'h22; apply(); tick();
    rv = 4'b0100; ra[2] = 32'h33; apply(); tick();
    rv = 0; apply(); tick(); tick();
    ap_rst_n = 1'b0; apply(); tick();
    ap_rst_n = 1'b1; apply();
    cnt = 0;
    repeat (LATENCY + 3) begin tick(); if (resp_valid != 0) cnt++; end
    chk("flush_no_resp", 32'(cnt), 32'd0);
    rv = 4'b0010; ra[1] = 32'hCAFE0000; rb[1] = 32'h0000BEEF; apply(); tick();
    rv = 0; apply();
    repeat (LATENCY + 1) tick();
    chk("post_rst_resp_valid", {28'b0, resp_valid}, 32'b0010);
    chk("post_rst_resp_data", resp_data, 32'hCAFEBEEF);

    // 20 back-to-back ops from requester 0.
    cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 20 + LATENCY + 4; i++) begin
      rv = (i < 20) ? 4'b0001 : 4'b0000;
      ra[0] = $urandom; rb[0] = $urandom;
      apply(); tick();
      if (resp_valid[0]) begin cnt++; if (first < 0) first = i; last = i; end
    end
    chk("stream_count", 32'(cnt), 32'd20);
    chk("stream_span", 32'(last - first), 32'd19);
    chk("stream_latency", 32'(first), 32'(LATENCY + 1));

    // Randomized traffic with legal request holding and rare resets.
    rv = 0;
    for (int i = 0; i < 400; i++) begin
      ap_rst_n = ($urandom_range(0, 99) != 0);
      for (int j = 0; j < 4; j++) begin
        if (!rv[j] || m_acc == j) begin
          rv[j] = ($urandom_range(0, 2) != 0);
          ra[j] = $urandom; rb[j] = $urandom;
        end else if ($urandom_range(0, 9) == 0) begin
          rv[j] = 1'b0;
        end
      end
      apply(); tick();
    end
    ap_rst_n = 1'b1; rv = 0; apply();
    repeat (LATENCY + 4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
